dadda_mul_arbiter: RTL and testbench

- Shares one combinational 8x8 unsigned Dadda multiplier (`dadda` module) among NUM_REQ requesters.
- Round-robin arbitration, registered operands, registered 16-bit product.
- Valid/ready handshake on each request port and on the single response port.
- Sits between client datapaths and the shared multiplier instance, which it instantiates internally.

---
 rtl/dadda_mul_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_dadda_mul_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: round-robin arbiter that time-shares one combinational
// 8x8 unsigned Dadda multiplier among NUM_REQ requesters. Each request is
// accepted in IDLE, multiplied in CALC and returned in RESP under a
// valid/ready handshake.
// Optional build macro DADDA_MUL_ARB_STATS_EN adds saturating 16-bit
// txn_count and stall_count outputs.

module dadda (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  localparam int NST = 4;
  localparam int DSEQ [NST] = '{6, 4, 3, 2};

  logic [15:0] row0;
  logic [15:0] row1;

  // Dadda reduction: partial-product columns are reduced to heights 6,4,3,2,
  // using a half adder when one bit of reduction suffices, else a full adder
  always_comb begin
    logic [15:0] col [16];
    logic [15:0] nxt [17];
    int h [16];
    int nh [17];
    int k;
    int r;
    k = 0;
    r = 0;
    row0 = '0;
    row1 = '0;
    for (int c = 0; c < 16; c++) begin
      col[c] = '0;
      h[c] = 0;
    end
    for (int c = 0; c < 17; c++) begin
      nxt[c] = '0;
      nh[c] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col[i+j][h[i+j][3:0]] = a[i] & b[j];
        h[i+j] = h[i+j] + 1;
      end
    end
    for (int s = 0; s < NST; s++) begin
      for (int c = 0; c < 17; c++) begin
        nxt[c] = '0;
        nh[c] = 0;
      end
      for (int c = 0; c < 16; c++) begin
        k = 0;
        for (int t = 0; t < 8; t++) begin
          r = h[c] - k + nh[c];
          if (r > DSEQ[s]) begin
            if (r == DSEQ[s] + 1) begin
              nxt[c][nh[c][3:0]] = col[c][k[3:0]] ^ col[c][4'(k + 1)];
              nxt[c+1][nh[c+1][3:0]] = col[c][k[3:0]] & col[c][4'(k + 1)];
              nh[c] = nh[c] + 1;
              nh[c+1] = nh[c+1] + 1;
              k = k + 2;
            end else begin
              nxt[c][nh[c][3:0]] = col[c][k[3:0]] ^ col[c][4'(k + 1)] ^ col[c][4'(k + 2)];
              nxt[c+1][nh[c+1][3:0]] = (col[c][k[3:0]] & col[c][4'(k + 1)]) |
                                       (col[c][k[3:0]] & col[c][4'(k + 2)]) |
                                       (col[c][4'(k + 1)] & col[c][4'(k + 2)]);
              nh[c] = nh[c] + 1;
              nh[c+1] = nh[c+1] + 1;
              k = k + 3;
            end
          end
        end
        for (int t = 0; t < 16; t++) begin
          if (t >= k && t < h[c]) begin
            nxt[c][nh[c][3:0]] = col[c][t];
            nh[c] = nh[c] + 1;
          end
        end
      end
      for (int c = 0; c < 16; c++) begin
        col[c] = nxt[c];
        h[c] = nh[c];
      end
    end
    for (int c = 0; c < 16; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
  end

  assign p = row0 + row1;
endmodule

module dadda_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_prod,
  output logic [ID_W-1:0]        rsp_id
`ifdef DADDA_MUL_ARB_STATS_EN
  ,
  output logic [15:0]            txn_count,
  output logic [15:0]            stall_count
`endif
);
  localparam int NSLOT = 2**ID_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             grant;
  logic [NSLOT-1:0] valid_pad;
  logic [7:0]       a_arr [NSLOT];
  logic [7:0]       b_arr [NSLOT];
  logic [7:0]       op_a_p1;
  logic [7:0]       op_b_p1;
  logic [ID_W-1:0]  id_p1;
  logic [15:0]      prod_p2;
  logic [15:0]      mul_out;

  dadda u_dadda (
    .a (op_a_p1),
    .b (op_b_p1),
    .p (mul_out)
  );

  // Unpack per-requester operands into index-addressable slots
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = req_a[8*k +: 8];
      b_arr[k] = req_b[8*k +: 8];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int cand;
    cand = 0;
    winner = '0;
    found = 1'b0;
    valid_pad = NSLOT'(req_valid);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && valid_pad[ID_W'(cand)]) begin
        found = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  // One-hot ready to the winner while idle; held low during reset
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = rst_n && (state == IDLE) && found && (winner == ID_W'(k));
    end
  end

  assign grant     = rst_n && (state == IDLE) && found;
  assign rsp_valid = (state == RESP);
  assign rsp_prod  = prod_p2;
  assign rsp_id    = id_p1;

  // Control FSM with operand capture (p1) and product register (p2)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      op_a_p1 <= '0;
      op_b_p1 <= '0;
      id_p1   <= '0;
      prod_p2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          // stage p1: operands and owner captured on the grant edge
          if (grant) begin
            op_a_p1 <= a_arr[winner];
            op_b_p1 <= b_arr[winner];
            id_p1   <= winner;
            rr_ptr  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            state   <= CALC;
          end
        end
        CALC: begin
          // stage p2: multiplier result registered
          prod_p2 <= mul_out;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DADDA_MUL_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counters for completed responses and backpressured cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count   <= '0;
      stall_count <= '0;
    end else begin
      if (state == RESP && rsp_ready)  txn_count   <= sat_inc(txn_count);
      if (state == RESP && !rsp_ready) stall_count <= sat_inc(stall_count);
    end
  end
`endif
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Self-checking bench for dadda_mul_arbiter: expected responses are queued
// when requests are driven and popped when the response handshake occurs.
module tb_dadda_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [15:0]          rsp_prod;
  logic [ID_W-1:0]      rsp_id;
`ifdef DADDA_MUL_ARB_STATS_EN
  logic [15:0]          txn_count;
  logic [15:0]          stall_count;
`endif

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     prod;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  dadda_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id)
`ifdef DADDA_MUL_ARB_STATS_EN
    ,
    .txn_count   (txn_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Response monitor: every accepted response must match the queue head
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic push(input int i, input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back('{id: ID_W'(i), prod: 16'(a) * 16'(b)});
  endtask

  task automatic drain();
    int w;
    w = 0;
    #1;
    while (exp_q.size() != 0 && w < 30) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  task automatic single(input int i, input logic [7:0] a, input logic [7:0] b);
    drive(i, a, b);
    req_valid = NUM_REQ'(1) << i;
    @(negedge clk);
    chk("single_rdy", 32'(req_ready), 32'd1 << i);
    push(i, a, b);
    tick();
    req_valid = '0;
    drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    int last;
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // requester 2 alone, 0xFF * 0xFF, two-cycle latency
    drive(2, 8'hFF, 8'hFF);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_rdy", 32'(req_ready), 32'h4);
    push(2, 8'hFF, 8'hFF);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_lat1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_lat2_valid", 32'(rsp_valid), 32'd1);
    chk("t1_prod", 32'(rsp_prod), 32'hFE01);
    chk("t1_id", 32'(rsp_id), 32'd2);
    drain();

    // all four requesting: round-robin order and 3-cycle spacing
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) drive(i, 8'(i + 1), 8'h10);
    for (int g = 0; g < 5; g++) push(g % 4, 8'((g % 4) + 1), 8'h10);
    req_valid = 4'hF;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (req_ready == '0 && w < 12);
      chk("rr_grant", 32'(req_ready), 32'd1 << (g % 4));
      if (g > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      tick();
    end
    req_valid = '0;
    drain();
`ifdef DADDA_MUL_ARB_STATS_EN
    chk("txn_count", 32'(txn_count), 32'd5);
`endif

    // backpressure: response held for 5 cycles
    rsp_ready = 1'b0;
    drive(1, 8'h0C, 8'h0D);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_rdy", 32'(req_ready), 32'h2);
    push(1, 8'h0C, 8'h0D);
    tick();
    req_valid = 4'b0001;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rsp_valid && w < 10);
    for (int s = 0; s < 5; s++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_prod", 32'(rsp_prod), 32'h009C);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
      if (s < 4) @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_release", 32'(rsp_valid), 32'd0);
`ifdef DADDA_MUL_ARB_STATS_EN
    chk("stall_count", 32'(stall_count), 32'd5);
`endif
    tick();

    // corner operands, each followed by 0xAA * 0x55
    single(0, 8'h00, 8'hFF);
    single(0, 8'hAA, 8'h55);
    single(3, 8'h80, 8'h02);
    single(0, 8'hAA, 8'h55);
    single(1, 8'h01, 8'hFF);
    single(0, 8'hAA, 8'h55);

    // reset while in CALC discards the transaction and clears rr_ptr
    drive(2, 8'h11, 8'h22);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_grant_rdy", 32'(req_ready), 32'h4);
    tick();
    rst_n = 1'b0;
    req_valid = 4'b1001;
    drive(0, 8'h03, 8'h05);
    drive(3, 8'h07, 8'h09);
    tick();
    @(negedge clk);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_first_grant", 32'(req_ready), 32'h1);
    push(0, 8'h03, 8'h05);
    push(3, 8'h07, 8'h09);
    tick();
    req_valid = 4'b1000;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (req_ready == '0 && w < 12);
    chk("mid_second_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
